// File: rtl/sram_fifo_pkg.sv
// Shared helpers for the SRAM FIFO read-side blocks: lane counter sizing and
// the lane-valid mask produced from a lane count.
package sram_fifo_pkg;

   // A counter that must hold 0..ratio inclusive needs one extra code point.
   function automatic int lane_cnt_w(input int ratio);
      return $clog2(ratio + 1);
   endfunction

   // Low cnt bits set; cnt == RATIO naturally yields the all-ones mask.
   function automatic logic [31:0] keep_mask(input logic [31:0] cnt);
      return (32'd1 << cnt) - 32'd1;
   endfunction

endpackage

// File: rtl/fifo_burst_reader.sv
// Pops words from a show-ahead FIFO, packs RATIO of them into one wide beat and
// presents it on a valid/ready port; a flush request closes a partial beat early.
module fifo_burst_reader
   import sram_fifo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int RATIO = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     fifo_empty_i,
   input  logic [WIDTH-1:0]         fifo_data_i,
   output logic                     fifo_rd_en_o,
   input  logic                     flush_i,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic [WIDTH*RATIO-1:0]   m_data_o,
   output logic [RATIO-1:0]         m_keep_o
);

   localparam int CW = lane_cnt_w(RATIO);
   localparam logic [CW-1:0] FULL_CNT = CW'(RATIO);

   logic [CW-1:0]            laneCnt_q, laneCnt_d;
   logic [CW-1:0]            popIdx;
   logic                     flushPend_q, flushPend_d;
   logic                     mValid_q;
   logic [WIDTH*RATIO-1:0]   mData_q;
   logic [RATIO-1:0]         mKeep_q;
   logic [WIDTH*RATIO-1:0]   asmLanes;
   logic [WIDTH*RATIO-1:0]   xferData;
   logic [RATIO-1:0]         xferKeep;
   logic                     asmFull, outFree, xfer, rdEn;

   // Decide beat transfer, pop permission and where the popped word lands.
   // A pop in the same cycle as a transfer starts the next beat at lane 0.
   always_comb begin
      asmFull     = (laneCnt_q == FULL_CNT);
      outFree     = ~mValid_q | m_ready_i;
      xfer        = outFree & (asmFull | (flushPend_q & (laneCnt_q != '0)));
      rdEn        = ~rst_i & ~fifo_empty_i & ~flushPend_q & (~asmFull | xfer);
      popIdx      = xfer ? '0 : laneCnt_q;
      laneCnt_d   = popIdx + CW'(rdEn);
      xferKeep    = RATIO'(keep_mask(32'(laneCnt_q)));
      xferData    = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (xferKeep[k]) begin
            xferData[k*WIDTH +: WIDTH] = asmLanes[k*WIDTH +: WIDTH];
         end
      end
      // An empty assembly never produces a beat, so a pending flush with
      // nothing collected simply dissolves.
      if (flushPend_q) begin
         flushPend_d = ~(xfer | (laneCnt_q == '0));
      end else begin
         flushPend_d = flush_i;
      end
   end

   for (genvar k = 0; k < RATIO; k++) begin : g_lane
      logic [WIDTH-1:0] lane_q;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            lane_q <= '0;
         end else if (rdEn && (popIdx == CW'(k))) begin
            lane_q <= fifo_data_i;
         end
      end

      assign asmLanes[k*WIDTH +: WIDTH] = lane_q;
   end

   // Output register holds the beat steady until accepted; it reloads in the
   // accept cycle itself when another beat is ready, so there is no bubble.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         laneCnt_q   <= '0;
         flushPend_q <= 1'b0;
         mValid_q    <= 1'b0;
         mData_q     <= '0;
         mKeep_q     <= '0;
      end else begin
         laneCnt_q   <= laneCnt_d;
         flushPend_q <= flushPend_d;
         if (outFree) begin
            mValid_q <= xfer;
         end
         if (xfer) begin
            mData_q <= xferData;
            mKeep_q <= xferKeep;
         end
      end
   end

   assign fifo_rd_en_o = rdEn;
   assign m_valid_o    = mValid_q;
   assign m_data_o     = mData_q;
   assign m_keep_o     = mKeep_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Drives fifo_burst_reader from a queue-based show-ahead FIFO model and checks
// every accepted beat against a scoreboard of expected {keep,data} values.
module tb_fifo_burst_reader;

   localparam int WIDTH = 8;
   localparam int RATIO = 4;

   logic                   clk_i = 1'b0;
   logic                   rst_i;
   logic                   fifo_empty_i;
   logic [WIDTH-1:0]       fifo_data_i;
   logic                   fifo_rd_en_o;
   logic                   flush_i;
   logic                   m_valid_o;
   logic                   m_ready_i;
   logic [WIDTH*RATIO-1:0] m_data_o;
   logic [RATIO-1:0]       m_keep_o;

   int checks = 0;
   int errors = 0;
   int cycle = 0;
   int popCount = 0;
   int firstPopCycle = 0;
   int lastPopCycle = 0;
   int beatCount = 0;
   int firstBeatCycle = 0;
   int lastBeatCycle = 0;

   logic [WIDTH-1:0] fifoQ[$];
   logic [63:0]      sbQ[$];

   fifo_burst_reader #(.WIDTH(WIDTH), .RATIO(RATIO)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .fifo_empty_i (fifo_empty_i),
      .fifo_data_i  (fifo_data_i),
      .fifo_rd_en_o (fifo_rd_en_o),
      .flush_i      (flush_i),
      .m_valid_o    (m_valid_o),
      .m_ready_i    (m_ready_i),
      .m_data_o     (m_data_o),
      .m_keep_o     (m_keep_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   function automatic logic [63:0] beat(input logic [RATIO-1:0] keep, input logic [WIDTH*RATIO-1:0] data);
      return {28'd0, keep, data};
   endfunction

   // FIFO model: pops happen on the clock edge the DUT strobes rd_en.
   always @(posedge clk_i) begin
      cycle <= cycle + 1;
      if (fifo_rd_en_o) begin
         if (fifoQ.size() == 0) begin
            checkOutput("underflow", 64'd1, 64'd0);
         end else begin
            void'(fifoQ.pop_front());
            if (popCount == 0) firstPopCycle = cycle;
            lastPopCycle = cycle;
            popCount++;
         end
      end
      fifo_empty_i <= (fifoQ.size() == 0);
      fifo_data_i  <= (fifoQ.size() != 0) ? fifoQ[0] : '0;
   end

   // Beat monitor: inputs are stable between negedge and the next posedge.
   always @(negedge clk_i) begin
      if (!rst_i && m_valid_o && m_ready_i) begin
         if (beatCount == 0) firstBeatCycle = cycle;
         lastBeatCycle = cycle;
         beatCount++;
         if (sbQ.size() == 0) begin
            checkOutput("unexpectedBeat", beat(m_keep_o, m_data_o), 64'd0);
         end else begin
            checkOutput("beat", beat(m_keep_o, m_data_o), sbQ.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pushWord(input logic [WIDTH-1:0] w);
      fifoQ.push_back(w);
      fifo_empty_i = 1'b0;
      fifo_data_i  = fifoQ[0];
   endtask

   task automatic applyStimulus(input logic [WIDTH-1:0] first, input int n);
      for (int i = 0; i < n; i++) pushWord(first + WIDTH'(i));
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      if (sbQ.size() != 0) checkOutput("drainTimeout", 64'(sbQ.size()), 64'd0);
   endtask

   task automatic waitPops(input int target, input int budget);
      int n;
      n = 0;
      while (popCount < target && n < budget) begin
         tick();
         n++;
      end
      if (popCount < target) checkOutput("popTimeout", 64'(popCount), 64'(target));
   endtask

   task automatic pulseFlush();
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_i        = 1'b1;
      flush_i      = 1'b0;
      m_ready_i    = 1'b0;
      fifo_empty_i = 1'b1;
      fifo_data_i  = '0;
      repeat (3) tick();
      checkOutput("rstValid", 64'(m_valid_o), 64'd0);
      checkOutput("rstData",  64'(m_data_o),  64'd0);
      checkOutput("rstKeep",  64'(m_keep_o),  64'd0);
      checkOutput("rstRdEn",  64'(fifo_rd_en_o), 64'd0);
      rst_i = 1'b0;
      tick();

      // Plain streaming of two full beats.
      m_ready_i = 1'b1;
      applyStimulus(8'h01, 8);
      sbQ.push_back(beat(4'hF, 32'h04030201));
      sbQ.push_back(beat(4'hF, 32'h08070605));
      waitDrain(40);

      // Partial beat: the word popped in the flush cycle is still included.
      popCount = 0;
      pushWord(8'hA1);
      pushWord(8'hA2);
      waitPops(2, 20);
      pushWord(8'hA3);
      pushWord(8'hB1);
      sbQ.push_back(beat(4'h7, 32'h00A3A2A1));
      pulseFlush();
      checkOutput("flushBlocksPop", 64'(fifo_rd_en_o), 64'd0);
      waitDrain(20);
      waitPops(4, 20);
      sbQ.push_back(beat(4'h1, 32'h000000B1));
      pulseFlush();
      waitDrain(20);

      // Flush with nothing assembled: no beat, pending clears after one cycle.
      popCount = 0;
      pulseFlush();
      pushWord(8'hC1);
      #1;
      checkOutput("emptyFlushPend", 64'(fifo_rd_en_o), 64'd0);
      checkOutput("emptyFlushNoBeat", 64'(m_valid_o), 64'd0);
      tick();
      checkOutput("emptyFlushClear", 64'(fifo_rd_en_o), 64'd1);
      checkOutput("emptyFlushNoBeat2", 64'(m_valid_o), 64'd0);
      waitPops(1, 10);
      sbQ.push_back(beat(4'h1, 32'h000000C1));
      pulseFlush();
      waitDrain(20);

      // Backpressure: one beat held at the output plus one full assembly.
      m_ready_i = 1'b0;
      popCount = 0;
      applyStimulus(8'h10, 12);
      repeat (10) tick();
      checkOutput("bpPopCount", 64'(popCount), 64'(2 * RATIO));
      checkOutput("bpValid", 64'(m_valid_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         checkOutput("bpHoldData", 64'(m_data_o), 64'h13121110);
         checkOutput("bpNoPop", 64'(fifo_rd_en_o), 64'd0);
         tick();
      end
      sbQ.push_back(beat(4'hF, 32'h13121110));
      sbQ.push_back(beat(4'hF, 32'h17161514));
      sbQ.push_back(beat(4'hF, 32'h1B1A1918));
      m_ready_i = 1'b1;
      waitDrain(40);

      // Sustained throughput: one pop per cycle and evenly spaced beats.
      popCount  = 0;
      beatCount = 0;
      applyStimulus(8'h20, 16);
      sbQ.push_back(beat(4'hF, 32'h23222120));
      sbQ.push_back(beat(4'hF, 32'h27262524));
      sbQ.push_back(beat(4'hF, 32'h2B2A2928));
      sbQ.push_back(beat(4'hF, 32'h2F2E2D2C));
      waitDrain(60);
      checkOutput("b2bPops", 64'(popCount), 64'd16);
      checkOutput("b2bPopSpan", 64'(lastPopCycle - firstPopCycle), 64'd15);
      checkOutput("b2bBeats", 64'(beatCount), 64'd4);
      checkOutput("b2bBeatSpan", 64'(lastBeatCycle - firstBeatCycle), 64'd12);

      // Reset with a beat waiting and two lanes assembled.
      m_ready_i = 1'b0;
      popCount  = 0;
      applyStimulus(8'h30, 6);
      repeat (10) tick();
      checkOutput("preRstValid", 64'(m_valid_o), 64'd1);
      checkOutput("preRstPops", 64'(popCount), 64'd6);
      rst_i = 1'b1;
      pushWord(8'h36);
      #1;
      checkOutput("rstNoPop", 64'(fifo_rd_en_o), 64'd0);
      tick();
      checkOutput("postRstValid", 64'(m_valid_o), 64'd0);
      checkOutput("postRstData",  64'(m_data_o),  64'd0);
      checkOutput("postRstKeep",  64'(m_keep_o),  64'd0);
      checkOutput("postRstPops",  64'(popCount),  64'd6);
      rst_i     = 1'b0;
      m_ready_i = 1'b1;
      waitPops(7, 10);
      sbQ.push_back(beat(4'h1, 32'h00000036));
      pulseFlush();
      waitDrain(20);
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
